// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and sizing helpers for the GPR write scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREG      = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  function automatic int unsigned CNT_MAX(input int unsigned cntW);
    return (32'd1 << cntW) - 32'd1;
  endfunction

  // Sized to hold the worst-case total of every tracked counter at its maximum.
  function automatic int unsigned OUT_W(input int unsigned nReg, input int unsigned cntW);
    return $clog2((nReg - 1) * CNT_MAX(cntW) + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: up on issue, down on retire, cleared by flush.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX(CNT_W));

  // A simultaneous issue and retire cancel, so only a lone retire can underflow.
  assign underflow = dec && !inc && !clr && (cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RSTn || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CntMax) cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight GPR writes and stalls ID on RAW hazards or a full per-register counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1,
  localparam int unsigned OutW     = OUT_W(NREG, CNT_W)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_wr_en,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic                 issue,
  output logic [OutW-1:0]      outstanding,
  output logic                 err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  incVec;
  logic [NREG-1:0]  decVec;
  logic [NREG-1:0]  uflowVec;

  // Register 0 is hardwired and never tracked.
  assign cnt[0]      = '0;
  assign incVec[0]   = 1'b0;
  assign decVec[0]   = 1'b0;
  assign uflowVec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gCnt
    assign incVec[r] = issue && id_wr_en && (id_rd == REG_IDX_W'(r));
    assign decVec[r] = wb_valid && (wb_rd == REG_IDX_W'(r));

    sb_counter #(
      .CNT_W(CNT_W)
    ) uCnt (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .inc      (incVec[r]),
      .dec      (decVec[r]),
      .clr      (flush),
      .cnt      (cnt[r]),
      .underflow(uflowVec[r])
    );
  end

  logic rsHit, rtHit, rdHit;
  logic rawRs, rawRt, wawFull;
  logic incAny, decAny;

  always_comb begin
    rsHit = wb_valid && (wb_rd == id_rs) && (id_rs != ZERO_REG);
    rtHit = wb_valid && (wb_rd == id_rt) && (id_rt != ZERO_REG);
    rdHit = wb_valid && (wb_rd == id_rd) && (id_rd != ZERO_REG);

    // A retire of the last pending write can forward through WB this same cycle.
    rawRs = id_use_rs && (id_rs != ZERO_REG) && (cnt[id_rs] != '0) &&
            !(WB_BYPASS && rsHit && (cnt[id_rs] == CntOne));
    rawRt = id_use_rt && (id_rt != ZERO_REG) && (cnt[id_rt] != '0) &&
            !(WB_BYPASS && rtHit && (cnt[id_rt] == CntOne));
    wawFull = id_wr_en && (id_rd != ZERO_REG) && (cnt[id_rd] == CntMax) && !rdHit;

    stall = id_valid && (rawRs || rawRt || wawFull);
    issue = id_valid && !stall;

    incAny = issue && id_wr_en && (id_rd != ZERO_REG);
    // A retire counts unless it hits an empty counter with no matching issue.
    decAny = wb_valid && (wb_rd != ZERO_REG) &&
             ((cnt[wb_rd] != '0) || (incAny && (id_rd == wb_rd)));
  end

  always_ff @(posedge CLK) begin
    if (!RSTn || flush) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OutW'(incAny) - OutW'(decAny);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      err_underflow <= 1'b0;
    end else if (|uflowVec) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized bench for reg_scoreboard against a per-register count model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam bit          Byp    = 1'b1;
  localparam int unsigned CntW   = 2;
  localparam int          CntTop = (1 << CntW) - 1;
  localparam int unsigned OW     = OUT_W(32, CntW);

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0, wb_rd = '0;
  logic          wb_valid = 1'b0, flush = 1'b0;
  logic          stall, issue, err_underflow;
  logic [OW-1:0] outstanding;

  reg_scoreboard #(
    .NREG     (32),
    .CNT_W    (CntW),
    .WB_BYPASS(Byp)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wr_en     (id_wr_en),
    .id_rd        (id_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .outstanding  (outstanding),
    .err_underflow(err_underflow)
  );

  always #5 CLK = ~CLK;

  int mcnt [32];
  int mout;
  bit merr;
  int nCmp = 0;
  int nFail = 0;
  bit lastStall, lastIssue;

  task automatic chk(input string tag, input int obs, input int exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit rawHaz(int r, bit use_, bit wbv, int wbrd);
    bit fwd;
    fwd = Byp && wbv && (wbrd == r) && (mcnt[r] == 1);
    return use_ && (r != 0) && (mcnt[r] != 0) && !fwd;
  endfunction

  function automatic bit wawHaz(bit wr, int rd, bit wbv, int wbrd);
    return wr && (rd != 0) && (mcnt[rd] == CntTop) && !(wbv && wbrd == rd);
  endfunction

  task automatic modelUpdate(bit rstn, bit ei, bit wr, int rd, bit wbv, int wbrd, bit fl);
    int ir, dr;
    if (!rstn || fl) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      if (!rstn) merr = 1'b0;
    end else begin
      ir = (ei && wr && rd != 0) ? rd : -1;
      dr = (wbv && wbrd != 0) ? wbrd : -1;
      if (!(ir >= 0 && ir == dr)) begin
        if (ir >= 0) mcnt[ir]++;
        if (dr >= 0) begin
          if (mcnt[dr] > 0) mcnt[dr]--;
          else merr = 1'b1;
        end
      end
    end
    mout = 0;
    foreach (mcnt[i]) mout += mcnt[i];
  endtask

  task automatic step(input bit rstn, input bit v, input int rs, input bit urs, input int rt,
                      input bit urt, input bit wr, input int rd, input bit wbv, input int wbrd,
                      input bit fl);
    bit es, ei;
    @(negedge CLK);
    RSTn = rstn; id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt);
    id_use_rt = urt; id_wr_en = wr; id_rd = 5'(rd); wb_valid = wbv; wb_rd = 5'(wbrd);
    flush = fl;
    #1;
    es = v && (rawHaz(rs, urs, wbv, wbrd) || rawHaz(rt, urt, wbv, wbrd) ||
               wawHaz(wr, rd, wbv, wbrd));
    ei = v && !es;
    chk("stall", int'(stall), int'(es));
    chk("issue", int'(issue), int'(ei));
    lastStall = stall;
    lastIssue = issue;
    @(posedge CLK);
    modelUpdate(rstn, ei, wr, rd, wbv, wbrd, fl);
    #1;
    chk("outstanding", int'(outstanding), mout);
    chk("err_underflow", int'(err_underflow), int'(merr));
  endtask

  initial begin
    int rs, rt, rd, wbrd, k;
    bit rstn, v, urs, urt, wr, wbv, fl;

    // Reset then idle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    chk("reset_out", int'(outstanding), 0);
    chk("reset_err", int'(err_underflow), 0);
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_issue", int'(lastIssue), 1);

    // Load-use RAW on r8, resolved by retire
    step(1, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    chk("raw_out1", int'(outstanding), 1);
    step(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_stall", int'(lastStall), 1);
    step(1, 1, 2, 0, 8, 1, 0, 0, 0, 0, 0);
    chk("raw_stall_rt", int'(lastStall), 1);
    step(1, 1, 8, 1, 0, 0, 0, 0, 1, 8, 0);
    chk("raw_bypass", int'(lastStall), Byp ? 0 : 1);
    chk("raw_out0", int'(outstanding), 0);
    step(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);

    // WAW saturation on r9
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("waw_full_stall", int'(lastStall), 1);
    step(1, 1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    chk("waw_retire_issue", int'(lastIssue), 1);
    chk("waw_out_hold", int'(outstanding), 3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    // Register 0 is untracked
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
    chk("r0_no_stall", int'(lastStall), 0);
    chk("r0_out", int'(outstanding), 0);
    chk("r0_err", int'(err_underflow), 0);

    // Flush squashes pending writes; simultaneous WB ignored
    for (int r = 1; r <= 4; r++) step(1, 1, 0, 0, 0, 0, 1, r, 0, 0, 0);
    chk("flush_pre_out", int'(outstanding), 4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("flush_out", int'(outstanding), 0);
    chk("flush_err", int'(err_underflow), 0);
    step(1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("flush_read12", int'(lastStall), 0);
    step(1, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
    chk("flush_read34", int'(lastStall), 0);

    // Underflow is sticky until reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    chk("uflow_set", int'(err_underflow), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    chk("uflow_sticky", int'(err_underflow), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    chk("uflow_clr", int'(err_underflow), 0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      rstn = ($urandom_range(0, 199) != 0);
      fl   = ($urandom_range(0, 59) == 0);
      v    = ($urandom_range(0, 3) != 0);
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      urs  = $urandom_range(0, 1);
      urt  = $urandom_range(0, 1);
      wr   = ($urandom_range(0, 2) != 0);
      rd   = $urandom_range(0, 7);
      wbv  = ($urandom_range(0, 2) == 0);
      wbrd = $urandom_range(0, 7);
      if (wbv && $urandom_range(0, 19) != 0) begin
        k = $urandom_range(1, 7);
        for (int j = 0; j < 7; j++) begin
          if (mcnt[((k + j - 1) % 7) + 1] != 0) begin
            wbrd = ((k + j - 1) % 7) + 1;
            break;
          end
        end
      end
      step(rstn, v, rs, urs, rt, urt, wr, rd, wbv, wbrd, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
